// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the CPU load/store path. Accepts one word request at a time over a
//   valid/ready handshake and waits LATENCY clock edges. It then performs a
//   byte-enabled store or a full-word load and returns a one-cycle response pulse.
//   While a request is being presented or is outstanding, it holds the requesting
//   stage through stall.
//
//   Ports
//     clk, rst              rising-edge clock, asynchronous active-high reset
//     req_valid/req_ready   request handshake (a request is accepted only in IDLE)
//     req_we                1 = store, 0 = load
//     req_addr              byte address; the word index is addr[DEPTH_LOG2+1:2]
//     req_wdata, req_be     store data and byte-lane enables (be is ignored on loads)
//     resp_valid            one-cycle response pulse
//     resp_rdata            load data (0 for stores and errors); held until the next response
//     resp_err              rejected request; only meaningful while resp_valid is high
//     stall                 hold the requesting pipeline stage
//
//   Build option
//     DMEM_RESPONDER_ERR_EN  when defined, misaligned or out-of-range addresses are
//                            flagged through resp_err and perform no access. When
//                            undefined, resp_err is 0 and addresses wrap modulo depth.
module dmem_responder #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH_LOG2    = 10,
   parameter int LATENCY       = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   input  logic                     req_we,
   input  logic [ADDRESS_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0]    req_wdata,
   input  logic [3:0]               req_be,
   output logic                     req_ready,
   output logic                     resp_valid,
   output logic [DATA_WIDTH-1:0]    resp_rdata,
   output logic                     resp_err,
   output logic                     stall
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t                  state;
   logic [3:0]              cnt;
   logic                    we_q;
   logic [DEPTH_LOG2-1:0]   idx_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [3:0]              be_q;
   logic                    err_q;
   logic                    addr_err;

   logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef DMEM_RESPONDER_ERR_EN
   // Reject word-misaligned addresses and any address beyond the array.
   assign addr_err = (req_addr[1:0] != 2'b00) ||
                     (req_addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2] != '0);
`else
   // Address bits outside the word index are deliberately dropped (wrap-around).
   logic unused_addr_bits;
   assign unused_addr_bits = ^{req_addr[ADDRESS_WIDTH-1:DEPTH_LOG2+2], req_addr[1:0]};
   assign addr_err = 1'b0;
`endif

   // The access edge is the WAIT->RESP transition. An asynchronous reset forces the
   // state to IDLE, so a pending store is dropped before it reaches memory.
   logic do_access;
   assign do_access = (state == S_WAIT) && (cnt == 4'd0);

   // Memory is never cleared. Only byte lanes that are enabled are written.
   always_ff @(posedge clk) begin
      if (!rst && do_access && we_q && !err_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= 4'd0;
         we_q       <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= '0;
         be_q       <= 4'd0;
         err_q      <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (req_valid) begin
                  we_q    <= req_we;
                  idx_q   <= req_addr[DEPTH_LOG2+1:2];
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  err_q   <= addr_err;
                  cnt     <= 4'(LATENCY - 1);
                  state   <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (cnt == 4'd0) begin
                  resp_valid <= 1'b1;
                  resp_err   <= err_q;
                  resp_rdata <= (we_q || err_q) ? '0 : mem[idx_q];
                  state      <= S_RESP;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end
            S_RESP: begin
               // resp_rdata keeps its value until the next response.
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // These outputs are gated with rst so that every output reads 0 while reset is held.
   assign req_ready = (state == S_IDLE) && !rst;
   assign stall     = !rst && (((state == S_IDLE) && req_valid) || (state == S_WAIT));

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_we;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        stall;

   dmem_responder #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH_LOG2(10), .LATENCY(2)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be), .req_ready(req_ready), .resp_valid(resp_valid),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .stall(stall)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   exp_t q[$];
   exp_t e;
   int   checks = 0;
   int   fails  = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
      end
   endfunction

   // Scoreboard monitor: every response pulse must match the oldest expectation.
   always @(negedge clk) begin
      if (!rst && resp_valid) begin
         if (q.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL unexpected_resp: got resp_valid=1 rdata=%h expected no response", resp_rdata);
         end else begin
            e = q.pop_front();
            chk("resp_rdata", resp_rdata, e.rdata);
            chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
         end
      end
   end

   // Presents a request at a negedge and returns at the negedge just after it is accepted.
   task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] xr, input logic xe,
                        input logic push);
      int n = 0;
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
      if (push) q.push_back('{rdata: xr, err: xe});
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         checks++; fails++;
         $display("FAIL accept_timeout: got req_ready=0 expected 1 within 50 cycles");
      end
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         checks++; fails++;
         $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   logic [31:0] w10;
   logic [31:0] w0;
   logic [31:0] w4;
   int t0;
   int t1;
   int not_ready;

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_ready", {31'b0, req_ready}, 32'd1);
      chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("reset_rdata", resp_rdata, 32'd0);
      chk("reset_stall", {31'b0, stall}, 32'd0);

      // Store with cycle-by-cycle timing checks.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEADBEEF; req_be = 4'hF;
      q.push_back('{rdata: 32'h0, err: 1'b0});
      #1;
      chk("stall_idle_req", {31'b0, stall}, 32'd1);
      chk("ready_idle", {31'b0, req_ready}, 32'd1);
      @(negedge clk);                     // after E0
      req_valid = 1'b0;
      chk("stall_wait0", {31'b0, stall}, 32'd1);
      chk("ready_wait0", {31'b0, req_ready}, 32'd0);
      chk("rv_wait0", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);                     // after E1
      chk("stall_wait1", {31'b0, stall}, 32'd1);
      chk("rv_wait1", {31'b0, resp_valid}, 32'd0);
      @(negedge clk);                     // after E2: RESP
      chk("rv_resp", {31'b0, resp_valid}, 32'd1);
      chk("stall_resp", {31'b0, stall}, 32'd0);
      chk("ready_resp", {31'b0, req_ready}, 32'd0);
      @(negedge clk);                     // after E3: IDLE
      chk("rv_after", {31'b0, resp_valid}, 32'd0);
      chk("ready_after", {31'b0, req_ready}, 32'd1);
      drain();

      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1);
      drain();

      // Partial store into byte lane 1.
      issue(1'b1, 32'h10, 32'h0000AA00, 4'b0010, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADAAEF, 1'b0, 1'b1);
      drain();
      // A store with no lanes enabled leaves the word unchanged.
      issue(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, 1'b0, 1'b1);
      issue(1'b0, 32'h10, 32'h0, 4'hF, 32'hDEADAAEF, 1'b0, 1'b1);
      drain();

      // Reset pulse while idle, with a request being presented.
      req_valid = 1'b1; req_addr = 32'h0; req_we = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
      chk("rst_rdata", resp_rdata, 32'd0);
      chk("rst_err", {31'b0, resp_err}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
      req_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_release_ready", {31'b0, req_ready}, 32'd1);
      @(negedge clk);

      // Set up words 0x0 and 0x4.
      issue(1'b1, 32'h0, 32'hCAFE0000, 4'hF, 32'h0, 1'b0, 1'b1);
      issue(1'b1, 32'h4, 32'h0000F00D, 4'hF, 32'h0, 1'b0, 1'b1);
      drain();

      // Misaligned and out-of-range loads.
      w10 = 32'hDEADAAEF;
      w0  = 32'hCAFE0000;
`ifdef DMEM_RESPONDER_ERR_EN
      issue(1'b0, 32'h13, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
      issue(1'b0, 32'h1000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
      // An erroring store must not write memory.
      issue(1'b1, 32'h1000, 32'h11111111, 4'hF, 32'h0, 1'b1, 1'b1);
      issue(1'b0, 32'h0, 32'h0, 4'h0, w0, 1'b0, 1'b1);
`else
      issue(1'b0, 32'h13, 32'h0, 4'h0, w10, 1'b0, 1'b1);
      issue(1'b0, 32'h1000, 32'h0, 4'h0, w0, 1'b0, 1'b1);
`endif
      drain();

      // A reset during WAIT discards the pending store and its response.
      issue(1'b1, 32'h20, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b1);
      drain();
      issue(1'b1, 32'h20, 32'h55555555, 4'hF, 32'h0, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      issue(1'b0, 32'h20, 32'h0, 4'h0, 32'h12345678, 1'b0, 1'b1);
      drain();

      // req_valid held high continuously: the two accepts must be LATENCY+2 = 4 cycles apart.
      w4 = 32'h0000F00D;
      req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = 4'h0;
      q.push_back('{rdata: w0, err: 1'b0});
      t0 = -1; t1 = -1; not_ready = 0;
      for (int c = 0; c < 20 && t1 < 0; c++) begin
         if (req_ready) begin
            if (t0 < 0) t0 = c;
            else t1 = c;
         end else if (t0 >= 0) begin
            not_ready++;
         end
         @(negedge clk);
         if (t0 >= 0 && t1 < 0 && req_addr == 32'h0) begin
            req_addr = 32'h4;
            q.push_back('{rdata: w4, err: 1'b0});
         end
      end
      req_valid = 1'b0;
      chk("b2b_spacing", 32'(t1 - t0), 32'd4);
      chk("b2b_not_ready", 32'(not_ready), 32'd3);
      drain();
      chk("scoreboard_empty", 32'(q.size()), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
